// File: rtl/acc_pkg.sv
// Shared types for the accumulator control sequencer.
// Holds the opcode and state encodings, the instruction field positions and the decoded control bundle.
package acc_pkg;

    localparam int INSTR_W  = 9;
    localparam int OP_MSB   = 8;
    localparam int OP_LSB   = 5;
    localparam int RS_MSB   = 4;
    localparam int RS_LSB   = 2;
    localparam int AMT_MSB  = 1;
    localparam int AMT_LSB  = 0;
    localparam int IMM5_MSB = 4;
    localparam int IMM5_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_ADDC = 4'b0001,
        OP_MOV0 = 4'b0010,
        OP_MOV1 = 4'b0011,
        OP_XOR0 = 4'b0100,
        OP_XOR1 = 4'b0101,
        OP_LD   = 4'b0110,
        OP_ST   = 4'b0111,
        OP_HALT = 4'b1000,
        OP_NOP  = 4'b1001,
        OP_SHL  = 4'b1010,
        OP_SHR  = 4'b1011,
        OP_BNE  = 4'b1100,
        OP_SET  = 4'b1101,
        OP_AND0 = 4'b1110,
        OP_AND1 = 4'b1111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef struct packed {
        logic [3:0] alu_cmd;
        logic       alu_sc_i;
        logic [2:0] rs_addr;
        logic       inb_imm;
        logic [7:0] imm;
        logic       wb_sel;
    } ctrl_t;

    function automatic opcode_t get_op(input logic [INSTR_W-1:0] instr);
        return opcode_t'(instr[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/acc_decode.sv
// Combinational instruction decoder.
// Maps a 9-bit instruction and the current carry flag onto the datapath control bundle.
module acc_decode
    import acc_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               sc_q,
    output ctrl_t              ctrl
);

    opcode_t    op;
    logic [4:0] imm5;

    assign op   = get_op(instr);
    assign imm5 = instr[IMM5_MSB:IMM5_LSB];

    // The shift direction bit is the opcode LSB; it is placed next to the amount so the ALU sees both in imm.
    always_comb begin
        ctrl         = '0;
        ctrl.alu_cmd = op;
        ctrl.rs_addr = instr[RS_MSB:RS_LSB];
        case (op)
            OP_ADDC: ctrl.alu_sc_i = sc_q;
            OP_SHL, OP_SHR: begin
                ctrl.inb_imm = 1'b1;
                ctrl.imm     = {5'b0, instr[OP_LSB], instr[AMT_MSB:AMT_LSB]};
            end
            OP_SET: begin
                ctrl.inb_imm = 1'b1;
                ctrl.imm     = {3'b0, imm5};
            end
            OP_BNE:  ctrl.imm    = {{3{imm5[4]}}, imm5};
            OP_LD:   ctrl.wb_sel = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_ctrl_seq.sv
// Multi-cycle control sequencer for the accumulator processor.
// Fetches from a synchronous ROM, registers decoded controls and owns the PC and the carry flag.
module acc_ctrl_seq
    import acc_pkg::*;
#(
    parameter int PC_W = 8
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    instr_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [3:0]         alu_cmd,
    output logic               alu_sc_i,
    input  logic               alu_sc_o,
    input  logic               alu_zero,
    output logic [2:0]         rs_addr,
    output logic               inb_imm,
    output logic [7:0]         imm,
    output logic               rf_we,
    output logic               wb_sel,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               done
);

    state_t             state;
    logic [PC_W-1:0]    pc;
    logic               sc_q;
    logic [INSTR_W-1:0] ir;
    ctrl_t              dec;
    opcode_t            ir_op;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_bne;

    acc_decode u_decode (
        .instr (instr_in),
        .sc_q  (sc_q),
        .ctrl  (dec)
    );

    assign instr_addr = pc;
    assign ir_op      = get_op(ir);
    assign pc_inc     = pc + PC_W'(1);
    assign pc_bne     = pc + {{(PC_W-5){ir[IMM5_MSB]}}, ir[IMM5_MSB:IMM5_LSB]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            sc_q     <= 1'b0;
            ir       <= '0;
            alu_cmd  <= '0;
            alu_sc_i <= 1'b0;
            rs_addr  <= '0;
            inb_imm  <= 1'b0;
            imm      <= '0;
            wb_sel   <= 1'b0;
            rf_we    <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: if (start) state <= FETCH;
                FETCH: state <= DECODE;
                DECODE: begin
                    ir       <= instr_in;
                    alu_cmd  <= dec.alu_cmd;
                    alu_sc_i <= dec.alu_sc_i;
                    rs_addr  <= dec.rs_addr;
                    inb_imm  <= dec.inb_imm;
                    imm      <= dec.imm;
                    wb_sel   <= dec.wb_sel;
                    state    <= EXEC;
                end
                EXEC: begin
                    if (ir_op inside {OP_ADD, OP_ADDC, OP_SHL, OP_SHR})
                        sc_q <= alu_sc_o;
                    case (ir_op)
                        OP_BNE: begin
                            pc    <= alu_zero ? pc_inc : pc_bne;
                            state <= FETCH;
                        end
                        OP_NOP: begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                        OP_LD, OP_ST: begin
                            mem_req <= 1'b1;
                            mem_we  <= (ir_op == OP_ST);
                            state   <= MEM;
                        end
                        OP_HALT: begin
                            pc    <= pc_inc;
                            done  <= 1'b1;
                            state <= HALT;
                        end
                        default: begin
                            pc    <= pc_inc;
                            rf_we <= 1'b1;
                            state <= WB;
                        end
                    endcase
                end
                // The PC of a load/store only moves once the memory has acknowledged.
                MEM: if (mem_ack) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    pc      <= pc_inc;
                    if (ir_op == OP_LD) begin
                        rf_we <= 1'b1;
                        state <= WB;
                    end else begin
                        state <= FETCH;
                    end
                end
                WB: state <= FETCH;
                HALT: if (start) begin
                    pc    <= '0;
                    done  <= 1'b0;
                    state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Directed self-checking bench for acc_ctrl_seq.
// A behavioural synchronous ROM feeds the sequencer; ALU and memory responses are driven by hand.
module tb_acc_ctrl_seq;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [PC_W-1:0] instr_addr;
    logic [8:0]      instr_in;
    logic [3:0]      alu_cmd;
    logic            alu_sc_i;
    logic            alu_sc_o = 1'b0;
    logic            alu_zero = 1'b0;
    logic [2:0]      rs_addr;
    logic            inb_imm;
    logic [7:0]      imm;
    logic            rf_we;
    logic            wb_sel;
    logic            mem_req;
    logic            mem_we;
    logic            mem_ack = 1'b0;
    logic            done;

    logic [8:0] rom [0:255];

    int checks   = 0;
    int failures = 0;

    acc_ctrl_seq #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr_addr (instr_addr),
        .instr_in   (instr_in),
        .alu_cmd    (alu_cmd),
        .alu_sc_i   (alu_sc_i),
        .alu_sc_o   (alu_sc_o),
        .alu_zero   (alu_zero),
        .rs_addr    (rs_addr),
        .inb_imm    (inb_imm),
        .imm        (imm),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears one cycle after the address.
    always @(posedge clk) instr_in <= rom[instr_addr];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic z, input logic sc, input logic ack);
        start    = s;
        alu_zero = z;
        alu_sc_o = sc;
        mem_ack  = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int req_cycles;
        int we_seen;

        for (int i = 0; i < 256; i++) rom[i] = 9'h120;

        // Program 1: set 5; add r1; halt
        rom[0] = 9'h1A5;
        rom[1] = 9'h004;
        rom[2] = 9'h100;

        tick(2);
        checkOutput("rst_addr", 32'(instr_addr), 32'h0);
        checkOutput("rst_cmd", 32'(alu_cmd), 32'h0);
        checkOutput("rst_imm", 32'(imm), 32'h0);
        checkOutput("rst_ctl", 32'({rf_we, wb_sel, inb_imm, mem_req, mem_we, done, alu_sc_i}), 32'h0);
        checkOutput("rst_rs", 32'(rs_addr), 32'h0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("p1_addr0", 32'(instr_addr), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("set_imm_exec", 32'(imm), 32'h05);
        checkOutput("set_cmd", 32'(alu_cmd), 32'hD);
        tick();
        checkOutput("set_wb_rfwe", 32'(rf_we), 32'h1);
        checkOutput("set_wb_imm", 32'(imm), 32'h05);
        checkOutput("p1_addr1", 32'(instr_addr), 32'h1);
        tick(3);
        checkOutput("add_cmd", 32'(alu_cmd), 32'h0);
        checkOutput("add_rs", 32'(rs_addr), 32'h1);
        tick(2);
        checkOutput("p1_addr2", 32'(instr_addr), 32'h2);
        tick(2);
        checkOutput("done_early", 32'(done), 32'h0);
        tick();
        checkOutput("done_11", 32'(done), 32'h1);

        // Program 2: carry chain, shift, branches, load and store
        rom[0]  = 9'h004;
        rom[1]  = 9'h024;
        rom[2]  = 9'h004;
        rom[3]  = 9'h163;
        rom[4]  = 9'h084;
        rom[5]  = 9'h024;
        rom[10] = 9'h19E;
        rom[11] = 9'h0CC;
        rom[12] = 9'h0E8;
        rom[13] = 9'h100;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("relaunch_done", 32'(done), 32'h0);
        checkOutput("relaunch_pc", 32'(instr_addr), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        tick(2);
        checkOutput("add1_sci", 32'(alu_sc_i), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("add1_wb", 32'({rf_we, wb_sel}), 32'h2);
        tick();
        checkOutput("add1_next", 32'({rf_we, instr_addr}), 32'h001);

        tick(2);
        checkOutput("addc_sci", 32'(alu_sc_i), 32'h1);
        checkOutput("addc_cmd", 32'(alu_cmd), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(4);
        checkOutput("add2_sci", 32'(alu_sc_i), 32'h0);
        tick(2);
        checkOutput("shr_addr", 32'(instr_addr), 32'h3);

        tick(2);
        checkOutput("shr_imm", 32'(imm), 32'h07);
        checkOutput("shr_inb", 32'(inb_imm), 32'h1);
        checkOutput("shr_cmd", 32'(alu_cmd), 32'hB);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("shr_wb", 32'(rf_we), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("xor_cmd", 32'({alu_cmd, inb_imm}), 32'h08);
        tick(4);
        checkOutput("addc_after_shr", 32'(alu_sc_i), 32'h1);
        tick(2);
        checkOutput("nop_addr6", 32'(instr_addr), 32'h6);
        tick(3);
        checkOutput("nop_3cyc", 32'({rf_we, instr_addr}), 32'h007);
        tick(9);
        checkOutput("bne_addr10", 32'(instr_addr), 32'd10);

        tick(2);
        checkOutput("bne_cmd", 32'(alu_cmd), 32'hC);
        tick();
        checkOutput("bne_taken", 32'(instr_addr), 32'd8);
        tick(8);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bne_not_taken", 32'(instr_addr), 32'd11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        tick(2);
        checkOutput("ld_exec", 32'({rs_addr, wb_sel, mem_req}), 32'b01110);
        tick();
        req_cycles = 0;
        we_seen    = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (mem_we !== 1'b0) we_seen++;
            applyStimulus(1'b0, 1'b0, 1'b0, (i == 3));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_req_cycles", 32'(req_cycles), 32'd4);
        checkOutput("ld_no_we", 32'(we_seen), 32'd0);
        checkOutput("ld_wb", 32'({mem_req, rf_we, wb_sel}), 32'b011);
        checkOutput("ld_pc", 32'(instr_addr), 32'd12);
        tick();
        checkOutput("ld_rfwe_pulse", 32'(rf_we), 32'h0);

        tick(2);
        checkOutput("st_exec", 32'({rs_addr, wb_sel}), 32'b0100);
        tick();
        checkOutput("st_mem", 32'({mem_req, mem_we}), 32'b11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("st_done", 32'({mem_req, mem_we, rf_we}), 32'b000);
        checkOutput("st_pc", 32'(instr_addr), 32'd13);

        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("halt2_done", 32'(done), 32'h1);
        tick();
        checkOutput("hold_start_relaunch", 32'({done, instr_addr}), 32'h000);
        tick(2);
        checkOutput("start_ignored", 32'({alu_cmd, instr_addr}), 32'h000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a load waits in MEM
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rom[0] = 9'h0CC;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("mid_mem_req", 32'(mem_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_req_drop", 32'(mem_req), 32'h0);
        checkOutput("async_outputs", 32'({alu_cmd, rs_addr, wb_sel, rf_we}), 32'h0);
        tick();
        reset = 1'b0;

        // Branch wrap in both directions around PC 0/255
        rom[0]   = 9'h19F;
        rom[255] = 9'h19F;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("bne_wrap_neg", 32'(instr_addr), 32'd255);
        tick(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("bne_wrap_255", 32'(instr_addr), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
